// File: rtl/neokeon_pkg.sv
// Shared types, round-constant defaults and GF(2^8) helpers
// for the Neokeon round controller.
package neokeon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] RC_INIT_DEF = 8'h80;
  localparam logic [7:0] RC_LAST_DEF = 8'hd4;
  localparam logic [7:0] RC_POLY     = 8'h1b;

  function automatic logic [7:0] xtime(
    input logic [7:0] v
  );
    return {v[6:0], 1'b0} ^ (v[7] ? RC_POLY : 8'h00);
  endfunction

  // Undo xtime: a set LSB means the reduction polynomial was folded in
  function automatic logic [7:0] inv_xtime(
    input logic [7:0] v
  );
    logic [7:0] t;
    t = v[0] ? (v ^ RC_POLY) : v;
    return {v[0], t[7:1]};
  endfunction

endpackage

// File: rtl/neokeon_round_controller_if.sv
// Handshake and datapath bundle between cipher top and round controller.
// NEOKEON_ABORT_EN adds the inAbort request line.
interface neokeon_round_controller_if;

  logic         inStart;
  logic         inDecrypt;
  logic [127:0] inDataState;
  logic [127:0] inRoundResult;
`ifdef NEOKEON_ABORT_EN
  logic         inAbort;
`endif
  logic [127:0] outRoundInput;
  logic [31:0]  outConstant1;
  logic [31:0]  outConstant2;
  logic         outFinal;
  logic         outBusy;
  logic         outValid;
  logic [127:0] outDataState;

  modport master (
`ifdef NEOKEON_ABORT_EN
    output inAbort,
`endif
    output inStart,
    output inDecrypt,
    output inDataState,
    output inRoundResult,
    input  outRoundInput,
    input  outConstant1,
    input  outConstant2,
    input  outFinal,
    input  outBusy,
    input  outValid,
    input  outDataState
  );

  modport slave (
`ifdef NEOKEON_ABORT_EN
    input  inAbort,
`endif
    input  inStart,
    input  inDecrypt,
    input  inDataState,
    input  inRoundResult,
    output outRoundInput,
    output outConstant1,
    output outConstant2,
    output outFinal,
    output outBusy,
    output outValid,
    output outDataState
  );

endinterface

// File: rtl/neokeon_rc_gen.sv
// 8-bit round-constant register: load an initial value, then step
// forward (encrypt) or backward (decrypt) through the xtime sequence.
module neokeon_rc_gen
  import neokeon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] init,
  input  logic       advance,
  input  logic       decrypt,
  output logic [7:0] rc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= 8'h00;
    end else if (load) begin
      rc <= init;
    end else if (advance) begin
      rc <= decrypt ? inv_xtime(rc) : xtime(rc);
    end
  end

endmodule

// File: rtl/neokeon_round_controller.sv
// Neokeon round sequencer: owns the working state, steps 16 rounds plus
// the final transform. NEOKEON_ABORT_EN enables mid-operation abort.
module neokeon_round_controller
  import neokeon_pkg::*;
#(
  parameter int         NUM_ROUNDS = 16,
  parameter logic [7:0] RC_INIT    = RC_INIT_DEF,
  parameter logic [7:0] RC_LAST    = RC_LAST_DEF
) (
  input  logic inClk,
  input  logic inRst,
  neokeon_round_controller_if.slave bus
);

  localparam int CW = $clog2(NUM_ROUNDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_ROUNDS - 1);

  state_t        state;
  state_t        state_nx;
  logic          decrypt_q;
  logic [CW-1:0] count;
  logic [127:0]  data_q;
  logic [127:0]  result_q;
  logic [7:0]    rc;
  logic [31:0]   rc_word;
  logic          rc_on;
  logic          start_ok;
  logic          adv;
  logic          load_res;
  logic          abort;

`ifdef NEOKEON_ABORT_EN
  assign abort = bus.inAbort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    adv      = 1'b0;
    load_res = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.inStart) begin
          start_ok = 1'b1;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          adv = 1'b1;
          if (count == CNT_LAST) begin
            state_nx = FINAL;
          end
        end
      end
      FINAL: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          load_res = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      data_q    <= '0;
      decrypt_q <= 1'b0;
      count     <= '0;
    end else if (start_ok) begin
      data_q    <= bus.inDataState;
      decrypt_q <= bus.inDecrypt;
      count     <= '0;
    end else if (adv) begin
      data_q    <= bus.inRoundResult;
      count     <= count + CW'(1);
    end
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      result_q <= '0;
    end else if (load_res) begin
      result_q <= bus.inRoundResult;
    end
  end

  // rc lands on RC_LAST (enc) / RC_INIT (dec) exactly when FINAL begins
  neokeon_rc_gen u_rc (
    .clk     (inClk),
    .rst     (inRst),
    .load    (start_ok),
    .init    (bus.inDecrypt ? RC_LAST : RC_INIT),
    .advance (adv),
    .decrypt (decrypt_q),
    .rc      (rc)
  );

  assign rc_on   = (state == ROUND) || (state == FINAL);
  assign rc_word = {24'h000000, rc};

  assign bus.outConstant1  = (rc_on && !decrypt_q) ? rc_word : 32'h0;
  assign bus.outConstant2  = (rc_on && decrypt_q) ? rc_word : 32'h0;
  assign bus.outRoundInput = data_q;
  assign bus.outDataState  = result_q;
  assign bus.outFinal      = (state == FINAL);
  assign bus.outBusy       = (state != IDLE);
  assign bus.outValid      = (state == DONE);

endmodule

// File: doc/neokeon_round_controller.md
Name: neokeon_round_controller

Overview:
- Sequences the Neokeon 128-bit block cipher through 16 rounds plus the final output transform.
- Owns the 128-bit working state register and feeds it to the round datapath (constant XOR, theta, pi, gamma).
- Generates the per-round constant in the low byte of constant1 (encrypt) or constant2 (decrypt).
- Provides a start/busy/valid handshake to the surrounding cipher top.

Parameters:
- NUM_ROUNDS, 16: number of full rounds; round counter width is clog2(NUM_ROUNDS+1).
- RC_INIT, 8'h80: round constant RC[0].
- RC_LAST, 8'hd4: RC[NUM_ROUNDS]; must equal RC_INIT advanced NUM_ROUNDS times by xtime.

Ports:
- inClk  in  1  clock, rising edge
- inRst  in  1  asynchronous, active-high reset
- inStart  in  1  start request; sampled only in IDLE
- inDecrypt  in  1  mode, sampled with inStart: 0 = encrypt, 1 = decrypt
- inDataState  in  128  plaintext/ciphertext, loaded on accepted start
- inRoundResult  in  128  round datapath output for the current outRoundInput/constants
- outRoundInput  out  128  working state register (drives round datapath)
- outConstant1  out  32  {24'b0, rc} in encrypt mode, else 0
- outConstant2  out  32  {24'b0, rc} in decrypt mode, else 0
- outFinal  out  1  datapath selects final transform (theta + constant only) instead of full round
- outBusy  out  1  high from accepted start until outValid cycle inclusive
- outValid  out  1  one-cycle pulse; result valid on outDataState
- outDataState  out  128  result register, held until next outValid

Behaviour:
- Reset (async, inRst=1): FSM=IDLE; state, result and rc registers = 0; all outputs 0.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: on inStart=1, load state<=inDataState, latch mode, round counter<=0, rc<=RC_INIT (encrypt) or RC_LAST (decrypt); next ROUND.
  - ROUND: each cycle, state<=inRoundResult, counter++, rc advances. After NUM_ROUNDS cycles go to FINAL.
  - FINAL: outFinal=1; rc = RC_LAST (encrypt) or RC_INIT (decrypt); result<=inRoundResult; next DONE.
  - DONE: outValid=1 for one cycle; next IDLE.
- rc update:
  - Encrypt uses forward xtime: rc<<1, XORed with 8'h1b if rc[7]=1.
  - Decrypt uses inverse: rc[0] ? ((rc^8'h1b)>>1)|8'h80 : rc>>1.
- Constant sequences:
  - Encrypt ROUND: 80,1b,36,6c,d8,ab,4d,9a,2f,5e,bc,63,c6,97,35,6a; FINAL: d4.
  - Decrypt ROUND: d4,6a,...,1b (reverse); FINAL: 80.
- Constant outputs: combinational from rc and mode. Both are 0 in IDLE and DONE.
- Latency: start sampled at edge 0 -> outValid high in cycle NUM_ROUNDS+2 (18 by default).
- Throughput: one block per NUM_ROUNDS+3 cycles; back-to-back start is accepted in the IDLE cycle following DONE.
- inStart in any state other than IDLE: ignored, no queuing. Mode and data changes while busy are ignored.
- inRst mid-operation: immediate return to IDLE; no outValid; outDataState cleared to 0.
- outDataState changes only on the FINAL->DONE edge or on reset.

Optional Feature:
- Macro NEOKEON_ABORT_EN adds port inAbort (in, 1).
- With the macro: inAbort=1 in ROUND or FINAL returns the FSM to IDLE at the next edge. No outValid; outDataState keeps its previous value; outBusy drops the following cycle. inAbort in IDLE/DONE has no effect.
- Without the macro: no port; the only way to stop an operation is reset.

Decomposition:
- Package neokeon_pkg holds:
  - FSM state encoding;
  - RC_INIT / RC_LAST defaults;
  - reduction constant 8'h1b;
  - xtime / inverse-xtime functions.
- Sub-module neokeon_rc_gen: 8-bit rc register with load (init value), advance and direction inputs.

Test Plan:
- Reset with inRst=1 mid-clock -> all outputs 0 asynchronously; outBusy=0.
- Encrypt start with inDataState=128'h2a78429b87c7d0924f26113f1d1349b2:
  - outRoundInput equals this value on the next cycle;
  - outConstant1 low byte steps 80,1b,...,6a, then d4 with outFinal=1;
  - outConstant2=0 throughout;
  - outValid in cycle 18, then outBusy=0.
- Decrypt start -> outConstant2 sequence d4,6a,35,...,1b, FINAL 80; outConstant1=0 throughout.
- Datapath model returns inRoundResult = outRoundInput ^ outConstant1 -> final outDataState equals input XOR the 17-constant accumulated byte.
- inStart pulsed at round 5 -> ignored, constants continue; inRst at round 5 -> IDLE, no outValid, outDataState=0.
- NEOKEON_ABORT_EN defined, inAbort at round 7 -> IDLE next cycle, prior outDataState retained; a new start completes normally.
